finish_arbiter: RTL
===================

Name: finish_arbiter

Overview:
- Arbitrates processor completion (`i_finish`) requests round-robin.
- For each granted processor it drives the scoreboard flush handshake, then returns a one-cycle one-hot ack to that processor.
- Sits between the processor array and the scoreboard, and replaces the fixed-priority finish handling inside the issuer.
- Guarantees no processor is starved when several finish together.

Parameters:
- PROC_COUNT, 4, number of processors / requesters (≥2).
- ID_W, 8, width of the command id each processor reports on finish.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with FINISH_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_finish  in  PROC_COUNT  per-processor finish request, level, held until acked.
- i_finish_id  in  PROC_COUNT*ID_W  finished cmd id per processor; slice p = bits [p*ID_W +: ID_W].
- o_map_flush  out  1  scoreboard flush request, level.
- o_map_cmd_id  out  ID_W  cmd id to flush.
- o_map_proc_id  out  $clog2(PROC_COUNT)  granted processor index.
- i_map_ack  in  1  scoreboard flush complete.
- o_ack  out  PROC_COUNT  one-hot, one-cycle ack to the granted processor.
- o_busy  out  1  high whenever state != IDLE.
- o_err  out  1  sticky watchdog error; tied 0 without FINISH_TIMEOUT_EN.

Behaviour:
- Reset (i_rst sampled high at posedge):
  - state=IDLE, rr_ptr=0, grant regs=0, mask=0.
  - All outputs 0 on the following cycle.
  - Reset mid-operation aborts the transaction; no o_ack is issued.
- Round-robin search:
  - Search order is rr_ptr, rr_ptr+1, … modulo PROC_COUNT.
  - After a grant to index g, rr_ptr=(g+1) mod PROC_COUNT, wrapping at PROC_COUNT-1→0.
- IDLE:
  - Effective requests = i_finish & ~mask.
  - If any is set: register grant index g and i_finish_id[g], then go to FLUSH.
  - Otherwise stay in IDLE.
  - mask clears every IDLE cycle.
- FLUSH:
  - o_map_flush=1; o_map_cmd_id and o_map_proc_id hold the registered values, stable for the whole state.
  - i_map_ack is sampled every cycle. On ack, go to SEND_ACK; o_map_flush drops on the next cycle.
  - An ack in the first FLUSH cycle is legal.
- SEND_ACK:
  - o_ack = 1<<g for exactly one cycle.
  - mask = 1<<g for the next IDLE cycle, so a processor that drops i_finish one cycle late is not re-granted.
  - Next state: IDLE.
- Latency:
  - i_finish high in IDLE at cycle N → o_map_flush high at N+1.
  - i_map_ack at cycle M → o_ack at M+1.
  - Back-to-back grants are separated by ≥1 IDLE cycle.
- Outputs outside FLUSH: o_map_flush=0, o_map_cmd_id=0, o_map_proc_id=0.
- Ignored inputs:
  - i_map_ack outside FLUSH.
  - i_finish changes after the grant is taken; i_finish_id is captured only at grant.
- A processor dropping i_finish while in FLUSH does not abort the transaction; o_ack is still issued.
- All outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- FINISH_TIMEOUT_EN, defined:
  - A counter clears on entry to FLUSH and increments each FLUSH cycle without i_map_ack.
  - When the counter reaches TIMEOUT_CYCLES: o_map_flush drops, return to IDLE with no o_ack, o_err=1 (sticky until reset).
  - rr_ptr still advances past g, so the timed-out processor is retried only after the others.
- FINISH_TIMEOUT_EN, undefined:
  - No counter; FLUSH waits indefinitely.
  - o_err is constant 0.

Test Plan:
- Single request: i_finish=4'b0100, id[2]=0x15 at cycle 1 → cycle 2 o_map_flush=1, cmd_id=0x15, proc_id=2; i_map_ack at cycle 5 → o_ack=4'b0100 at cycle 6 only; o_busy=0 at cycle 7.
- Simultaneous: i_finish=4'b1011 from reset, each processor drops its bit after its ack, ack returned 1 cycle after each flush → grant order 0,1,3, exactly one o_ack each, never two o_ack bits high together.
- Round-robin wrap: after a grant to 1, drive i_finish=4'b0011 → next grant 0 (search order 2,3,0,1), then 1.
- Late-drop mask: proc 0 holds i_finish one cycle after its o_ack while proc 2 requests → proc 2 granted, no re-grant to 0.
- Reset and stray ack: assert i_rst during FLUSH → next cycle all outputs 0, no o_ack; pulse i_map_ack in IDLE → no state change, o_ack stays 0.
- Timeout (FINISH_TIMEOUT_EN, TIMEOUT_CYCLES=8): i_finish=4'b0001, i_map_ack never asserted → o_map_flush high for 8 cycles, then o_err=1 held, no o_ack, o_busy=0 the next cycle.

Source files
------------

// File: rtl/finish_arbiter.sv
// finish_arbiter: round-robin arbiter for processor finish requests.
// Each grant runs a scoreboard flush handshake, then returns a one-cycle ack.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_finish[P]           per-processor finish request (level, held until acked)
//   i_finish_id[P*ID_W]   finished cmd id per processor, slice p = [p*ID_W +: ID_W]
//   o_map_flush           scoreboard flush request (level)
//   o_map_cmd_id          cmd id to flush
//   o_map_proc_id         granted processor index
//   i_map_ack             scoreboard flush complete
//   o_ack[P]              one-hot, one-cycle ack to the granted processor
//   o_busy                high whenever the arbiter is not idle
//   o_err                 sticky watchdog error
//
// Build option FINISH_TIMEOUT_EN: abandon a flush after TIMEOUT_CYCLES
// cycles without i_map_ack and raise o_err. Undefined: wait forever, o_err=0.

module finish_arbiter #(
    parameter int PROC_COUNT     = 4,
    parameter int ID_W           = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [PROC_COUNT-1:0]           i_finish,
    input  logic [PROC_COUNT*ID_W-1:0]      i_finish_id,
    output logic                            o_map_flush,
    output logic [ID_W-1:0]                 o_map_cmd_id,
    output logic [$clog2(PROC_COUNT)-1:0]   o_map_proc_id,
    input  logic                            i_map_ack,
    output logic [PROC_COUNT-1:0]           o_ack,
    output logic                            o_busy,
    output logic                            o_err
);

    localparam int PW = $clog2(PROC_COUNT);

    if (PROC_COUNT < 2) begin : g_bad_count
        $error("finish_arbiter: PROC_COUNT must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("finish_arbiter: TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        SEND_ACK
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PW-1:0]         rr_ptr_q;
    logic [PW-1:0]         grant_q;
    logic [ID_W-1:0]       id_q;
    logic [PROC_COUNT-1:0] mask_q;

    logic                  flush_q;
    logic [ID_W-1:0]       cmd_q;
    logic [PW-1:0]         pid_q;
    logic [PROC_COUNT-1:0] ack_q;
    logic                  busy_q;

    logic [PROC_COUNT-1:0] req;
    logic                  found;
    logic                  take;
    logic [PW-1:0]         pick;
    logic [PW-1:0]         pick_next;
    logic [ID_W-1:0]       pick_id;
    logic [PW:0]           sum;
    logic [PW-1:0]         idx;

`ifdef FINISH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout;
    logic          err_q;
`endif

    // Round-robin search starting at rr_ptr; the processor just acked is
    // masked for one IDLE cycle so a late drop of i_finish is not re-granted.
    always_comb begin
        req   = i_finish & ~mask_q;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < PROC_COUNT; i++) begin
            sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(PROC_COUNT)) begin
                sum = sum - (PW+1)'(PROC_COUNT);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        pick_id = '0;
        for (int i = 0; i < PROC_COUNT; i++) begin
            if (pick == PW'(i)) begin
                pick_id = i_finish_id[i*ID_W +: ID_W];
            end
        end
    end

    assign pick_next = (pick == PW'(PROC_COUNT - 1)) ? '0 : pick + PW'(1);

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
`ifdef FINISH_TIMEOUT_EN
        timeout = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = FLUSH;
                    take    = 1'b1;
                end
            end
            FLUSH: begin
                if (i_map_ack) begin
                    state_d = SEND_ACK;
`ifdef FINISH_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last ack-less cycle the watchdog allows.
                    state_d = IDLE;
                    timeout = 1'b1;
`endif
                end
            end
            SEND_ACK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            id_q     <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                grant_q  <= pick;
                id_q     <= pick_id;
                rr_ptr_q <= pick_next;
            end
            mask_q <= (state_q == SEND_ACK) ?
                      (PROC_COUNT'(1) << grant_q) : '0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flush_q <= 1'b0;
            cmd_q   <= '0;
            pid_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            flush_q <= (state_d == FLUSH);
            busy_q  <= (state_d != IDLE);
            cmd_q   <= (state_d != FLUSH) ? '0 : (take ? pick_id : id_q);
            pid_q   <= (state_d != FLUSH) ? '0 : (take ? pick : grant_q);
            ack_q   <= (state_d == SEND_ACK) ?
                       (PROC_COUNT'(1) << grant_q) : '0;
        end
    end

`ifdef FINISH_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (take) begin
                cnt_q <= '0;
            end else if (state_q == FLUSH && !i_map_ack) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_map_flush   = flush_q;
    assign o_map_cmd_id  = cmd_q;
    assign o_map_proc_id = pid_q;
    assign o_ack         = ack_q;
    assign o_busy        = busy_q;

endmodule
